// File: rtl/div_pipe.sv
`default_nettype none
// div_pipe: iterative RV32M DIV/DIVU/REM/REMU execution pipe (radix-2 restoring divider).
// Holds one instruction at a time; divide-by-zero and signed overflow may complete in one cycle.

package div_pipe_pkg;

   typedef enum logic [1:0] {
      DIV_OP_DIV  = 2'd0,
      DIV_OP_DIVU = 2'd1,
      DIV_OP_REM  = 2'd2,
      DIV_OP_REMU = 2'd3
   } div_op_e;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] rs1;
      logic [31:0] rs2;
      div_op_e     div_control;
   } ix_div_inf_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] result;
   } div_wb_inf_t;

endpackage

module div_pipe
   import div_pipe_pkg::*;
#(
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ix_div_valid,
   output logic        ix_div_ready,
   input  ix_div_inf_t ix_div_inf,
   input  logic        flush,
   output logic        div_busy,
   output logic [4:0]  div_busy_rd,
   output logic        div_wb_valid,
   input  logic        div_wb_ready,
   output div_wb_inf_t div_wb_inf
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e      state;
   logic [4:0]  count;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] b_mag;
   logic        neg_a;
   logic        neg_b;
   logic        special;
   logic [31:0] special_res;
   div_op_e     op;
   logic [4:0]  rd;

   logic        signed_in;
   logic        is_quot_in;
   logic        neg_a_in;
   logic        neg_b_in;
   logic [31:0] a_mag_in;
   logic [31:0] b_mag_in;
   logic        special_in;
   logic [31:0] special_res_in;

   always_comb begin
      signed_in  = (ix_div_inf.div_control == DIV_OP_DIV) || (ix_div_inf.div_control == DIV_OP_REM);
      is_quot_in = (ix_div_inf.div_control == DIV_OP_DIV) || (ix_div_inf.div_control == DIV_OP_DIVU);
      neg_a_in   = signed_in & ix_div_inf.rs1[31];
      neg_b_in   = signed_in & ix_div_inf.rs2[31];
      a_mag_in   = neg_a_in ? -ix_div_inf.rs1 : ix_div_inf.rs1;
      b_mag_in   = neg_b_in ? -ix_div_inf.rs2 : ix_div_inf.rs2;
      special_in     = 1'b0;
      special_res_in = '0;
      if (ix_div_inf.rs2 == 32'd0) begin
         special_in     = 1'b1;
         special_res_in = is_quot_in ? 32'hFFFF_FFFF : ix_div_inf.rs1;
      end else if (signed_in && (ix_div_inf.rs1 == 32'h8000_0000) &&
                   (ix_div_inf.rs2 == 32'hFFFF_FFFF)) begin
         special_in     = 1'b1;
         special_res_in = is_quot_in ? 32'h8000_0000 : 32'd0;
      end
   end

   // The partial remainder stays below |b|, so 32 bits hold it; bit 32 of the
   // trial subtraction is the sign that selects restore vs. keep.
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] result_fix;

   always_comb begin
      shifted    = {rem, quo[31]};
      trial      = shifted - {1'b0, b_mag};
      quo_fix    = (neg_a ^ neg_b) ? -quo : quo;
      rem_fix    = neg_a ? -rem : rem;
      result_fix = quo_fix;
      if (special) begin
         result_fix = special_res;
      end else if ((op == DIV_OP_REM) || (op == DIV_OP_REMU)) begin
         result_fix = rem_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         count       <= '0;
         quo         <= '0;
         rem         <= '0;
         b_mag       <= '0;
         neg_a       <= 1'b0;
         neg_b       <= 1'b0;
         special     <= 1'b0;
         special_res <= '0;
         op          <= DIV_OP_DIV;
         rd          <= '0;
         div_wb_inf  <= '0;
      end else if (flush) begin
         state <= ST_IDLE;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ix_div_valid) begin
                  rd          <= ix_div_inf.rd;
                  op          <= ix_div_inf.div_control;
                  neg_a       <= neg_a_in;
                  neg_b       <= neg_b_in;
                  b_mag       <= b_mag_in;
                  special     <= special_in;
                  special_res <= special_res_in;
                  quo         <= a_mag_in;
                  rem         <= '0;
                  count       <= '0;
                  if (FAST_SPECIAL && special_in) begin
                     div_wb_inf <= '{rd: ix_div_inf.rd, result: special_res_in};
                     state      <= ST_DONE;
                  end else begin
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (!trial[32]) begin
                  rem <= trial[31:0];
                  quo <= {quo[30:0], 1'b1};
               end else begin
                  rem <= shifted[31:0];
                  quo <= {quo[30:0], 1'b0};
               end
               if (count == 5'd31) begin
                  count <= '0;
                  state <= ST_FIX;
               end else begin
                  count <= count + 5'd1;
               end
            end
            ST_FIX: begin
               div_wb_inf <= '{rd: rd, result: result_fix};
               state      <= ST_DONE;
            end
            ST_DONE: begin
               if (div_wb_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ix_div_ready = (state == ST_IDLE);
   assign div_busy     = (state != ST_IDLE);
   assign div_wb_valid = (state == ST_DONE);
   assign div_busy_rd  = div_busy ? rd : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_div_pipe.sv
`default_nettype none
// tb_div_pipe: scoreboard bench for div_pipe with a fast-special and a slow-special instance.
`timescale 1ns/1ps
module tb_div_pipe;
   import div_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        sel = 1'b0;
   logic        valid = 1'b0;
   logic        wb_ready = 1'b0;
   ix_div_inf_t inf = '0;

   logic        f_valid, s_valid, f_wbr, s_wbr;
   logic        f_ready, s_ready, f_busy, s_busy, f_wbv, s_wbv;
   logic [4:0]  f_brd, s_brd;
   div_wb_inf_t f_wb, s_wb;

   logic        cur_ready, cur_busy, cur_wbv;
   logic [4:0]  cur_brd;
   div_wb_inf_t cur_wb;

   assign f_valid   = valid & ~sel;
   assign s_valid   = valid & sel;
   assign f_wbr     = wb_ready & ~sel;
   assign s_wbr     = wb_ready & sel;
   assign cur_ready = sel ? s_ready : f_ready;
   assign cur_busy  = sel ? s_busy  : f_busy;
   assign cur_wbv   = sel ? s_wbv   : f_wbv;
   assign cur_brd   = sel ? s_brd   : f_brd;
   assign cur_wb    = sel ? s_wb    : f_wb;

   div_pipe #(.FAST_SPECIAL(1'b1)) dut_fast (
      .clk(clk), .rst_n(rst_n), .ix_div_valid(f_valid), .ix_div_ready(f_ready),
      .ix_div_inf(inf), .flush(flush), .div_busy(f_busy), .div_busy_rd(f_brd),
      .div_wb_valid(f_wbv), .div_wb_ready(f_wbr), .div_wb_inf(f_wb)
   );

   div_pipe #(.FAST_SPECIAL(1'b0)) dut_slow (
      .clk(clk), .rst_n(rst_n), .ix_div_valid(s_valid), .ix_div_ready(s_ready),
      .ix_div_inf(inf), .flush(flush), .div_busy(s_busy), .div_busy_rd(s_brd),
      .div_wb_valid(s_wbv), .div_wb_ready(s_wbr), .div_wb_inf(s_wb)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   int unsigned acc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] res;
      int          lat;
   } exp_t;
   exp_t sb[$];

   function automatic logic [31:0] model(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      logic quot;
      sgn  = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
      quot = (op == DIV_OP_DIV) || (op == DIV_OP_DIVU);
      if (b == 32'd0) return quot ? 32'hFFFF_FFFF : a;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return quot ? 32'h8000_0000 : 32'd0;
      if (sgn) return quot ? 32'($signed(a) / $signed(b)) : 32'($signed(a) % $signed(b));
      return quot ? a / b : a % b;
   endfunction

   task automatic issue(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res, input int lat, input bit keep);
      int n;
      n = 0;
      @(negedge clk);
      while (!cur_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("issue_ready", 32'(cur_ready), 32'd1);
      valid = 1'b1;
      inf   = '{rd: rd, rs1: a, rs2: b, div_control: op};
      if (keep) sb.push_back('{rd: rd, res: res, lat: lat});
      @(negedge clk);
      valid = 1'b0;
      acc   = cyc;
      check("busy", 32'(cur_busy), 32'd1);
      check("busy_rd", 32'(cur_brd), 32'(rd));
   endtask

   task automatic collect(input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (!cur_wbv && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cur_wbv) begin
         check("wb_timeout", 32'd0, 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         check("unexpected_wb", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("latency", 32'(cyc - acc + 1), 32'(e.lat));
         check("wb_rd", 32'(cur_wb.rd), 32'(e.rd));
         check("wb_result", cur_wb.result, e.res);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(cur_wbv), 32'd1);
            check("hold_result", cur_wb.result, e.res);
            check("hold_ix_ready", 32'(cur_ready), 32'd0);
         end
      end
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      check("wb_valid_drop", 32'(cur_wbv), 32'd0);
      check("ready_after", 32'(cur_ready), 32'd1);
   endtask

   task automatic run(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] res, input int lat, input int hold);
      issue(op, a, b, rd, res, lat, 1'b1);
      collect(hold);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ix_ready"}, 32'(cur_ready), 32'd1);
      check({tag, "_busy"}, 32'(cur_busy), 32'd0);
      check({tag, "_busy_rd"}, 32'(cur_brd), 32'd0);
      check({tag, "_wb_valid"}, 32'(cur_wbv), 32'd0);
      check({tag, "_wb_rd"}, 32'(cur_wb.rd), 32'd0);
      check({tag, "_wb_result"}, cur_wb.result, 32'd0);
   endtask

   initial begin
      bit          seen;
      div_op_e     rop;
      logic [31:0] ra, rb;

      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run(DIV_OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34, 0);
      run(DIV_OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 34, 0);
      run(DIV_OP_DIV, 32'hFFFF_FFF9, 32'h2, 5'd5, 32'hFFFF_FFFD, 34, 0);
      run(DIV_OP_REM, 32'hFFFF_FFF9, 32'h2, 5'd6, 32'hFFFF_FFFF, 34, 0);

      run(DIV_OP_DIVU, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 1, 0);
      run(DIV_OP_REM, 32'h1234, 32'd0, 5'd8, 32'h1234, 1, 0);
      sel = 1'b1;
      run(DIV_OP_DIVU, 32'h1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 34, 0);
      run(DIV_OP_REM, 32'h1234, 32'd0, 5'd8, 32'h1234, 34, 0);
      run(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 34, 0);
      sel = 1'b0;

      run(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 0);
      run(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1, 0);
      run(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 34, 0);

      run(DIV_OP_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd13, 32'hFFFF_FF9C, 34, 5);
      run(DIV_OP_DIV, 32'hFFFF_FC18, 32'hFFFF_FFF6, 5'd14, 32'd100, 34, 0);

      issue(DIV_OP_DIVU, 32'd1000, 32'd3, 5'd15, 32'd0, 0, 1'b0);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_ix_ready", 32'(cur_ready), 32'd1);
      check("flush_busy", 32'(cur_busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cur_wbv) seen = 1'b1;
      end
      check("flush_no_wb", 32'(seen), 32'd0);

      valid = 1'b1;
      flush = 1'b1;
      inf   = '{rd: 5'd16, rs1: 32'd9, rs2: 32'd3, div_control: DIV_OP_DIVU};
      @(negedge clk);
      valid = 1'b0;
      flush = 1'b0;
      check("flush_accept_busy", 32'(cur_busy), 32'd0);

      run(DIV_OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd17, 32'hF, 34, 0);

      issue(DIV_OP_DIV, 32'd50, 32'd5, 5'd18, 32'd0, 0, 1'b0);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      run(DIV_OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'h8000_0001, 34, 0);

      for (int i = 0; i < 6; i++) begin
         rop = div_op_e'(2'($urandom_range(0, 3)));
         ra  = $urandom;
         rb  = $urandom >> $urandom_range(0, 28);
         if (rb == 32'd0) rb = 32'd1;
         run(rop, ra, rb, 5'(i + 20), model(rop, ra, rb), 34, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_pipe.md
# div_pipe

Iterative 32-bit integer divide execution pipe implementing RV32M DIV/DIVU/REM/REMU. It sits between issue (IX) and writeback (WB) as the `EXE_PIPE_ID_DIV` pipe, the lowest-priority requester at WB arbitration. It consumes `ix_div_inf_t` and produces `div_wb_inf_t`. It holds one instruction at a time: a radix-2 restoring divider with sign fix-up, plus a single-cycle path for divide-by-zero and signed overflow.

## Interface
Parameters:
- `FAST_SPECIAL`, default 1: when 1, divide-by-zero and overflow results complete in 1 cycle. When 0, they run the full iterative sequence; results must be identical either way.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ix_div_valid`  in  1  IX presents a DIV-pipe instruction.
- `ix_div_ready`  out  1  pipe can accept; high only in IDLE.
- `ix_div_inf`  in  `ix_div_inf_t`  fields `rd`[4:0], `rs1`[31:0], `rs2`[31:0], `div_control` (`div_op_e`).
- `flush`  in  1  kill the in-flight instruction (younger than a taken branch).
- `div_busy`  out  1  instruction held (CALC/FIX/DONE); used by IX hazard logic.
- `div_busy_rd`  out  5  `rd` of the held instruction; 0 when idle.
- `div_wb_valid`  out  1  result available.
- `div_wb_ready`  in  1  WB arbiter grants the DIV pipe.
- `div_wb_inf`  out  `div_wb_inf_t`  `rd`, `result`.

## Operation
- Accept: `ix_div_valid & ix_div_ready` on an edge latches `rd` and `div_control`, plus operands and sign flags:
  - `signed_op = (op==DIV_OP_DIV | op==DIV_OP_REM)`.
  - `neg_a = signed_op & rs1[31]`; `neg_b = signed_op & rs2[31]`.
  - Magnitudes: `|a| = neg_a ? -rs1 : rs1`; `|b|` likewise. This is 32-bit two's complement, so `|0x80000000| = 0x80000000` is treated as unsigned.
- Special cases, detected at accept:
  - `rs2 == 0`: DIV/DIVU result 0xFFFFFFFF; REM/REMU result `rs1`.
  - Signed overflow (op DIV/REM, `rs1 == 0x80000000`, `rs2 == 0xFFFFFFFF`): DIV result 0x80000000; REM result 0.
  - With `FAST_SPECIAL=1`, the result is loaded directly and the FSM goes to DONE.
- States: IDLE → CALC → FIX → DONE → IDLE.
  - IDLE: `ix_div_ready=1`. Accept → CALC with `count=0`, quotient register Q=|a|, partial remainder R=0 (33-bit). Special case with `FAST_SPECIAL=1` → DONE.
  - CALC: one iteration per cycle for 32 cycles.
    - `T = {R[31:0], Q[31]} - {1'b0, |b|}`.
    - If T is non-negative: `R = T`, `Q = {Q[30:0], 1}`.
    - Otherwise: `R = {R[31:0], Q[31]}`, `Q = {Q[30:0], 0}`.
    - After `count` reaches 31, go to FIX.
  - FIX, one cycle:
    - Quotient = `(neg_a ^ neg_b) ? -Q : Q`.
    - Remainder = `neg_a ? -R[31:0] : R[31:0]`.
    - Select by op into `div_wb_inf.result`; go to DONE.
  - DONE: `div_wb_valid=1`. On `div_wb_ready` at an edge → IDLE.
- `div_wb_inf` is stable while `div_wb_valid` is high. There is no combinational path from `ix_div_*` to `div_wb_*`.
- `flush` (any state) → IDLE on the next edge, with no result produced. A `flush` in the same cycle as an accept suppresses the accept.
- `rd=0` instructions execute normally; WB discards x0 writes.

## Timing
- Reset values: FSM=IDLE, `ix_div_ready=1`, `div_busy=0`, `div_busy_rd=0`, `div_wb_valid=0`, `div_wb_inf=0`, `count=0`.
- Normal latency: accept edge E0, CALC edges E1–E32, FIX edge E33. `div_wb_valid` is high from the cycle after E33, i.e. 34 cycles after accept.
- Special-case latency (`FAST_SPECIAL=1`): `div_wb_valid` is high the cycle after the accepting edge.
- Handshake: WB completes on the edge where `div_wb_valid & div_wb_ready`.
  - `ix_div_ready` rises the cycle after completion; there is no same-cycle back-to-back accept.
  - Issue interval is 35 cycles minimum.
- `div_wb_ready` low holds DONE indefinitely, with no change to outputs.
- `rst_n` low mid-operation: all outputs return to reset values immediately (asynchronous); the held instruction is lost.
- `flush` and `div_wb_ready` in the same DONE cycle: flush wins; the result counts as killed and IDLE is entered.

## Test plan
- DIVU 100/7 → 14; REMU 100/7 → 2; DIV −7/2 (0xFFFFFFF9, 0x2) → 0xFFFFFFFD; REM → 0xFFFFFFFF. Each `div_wb_valid` is exactly 34 cycles after accept, with `rd` echoed.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF; REM 0x1234/0 → 0x1234. Latency 1 with `FAST_SPECIAL=1` and 34 with `FAST_SPECIAL=0`; values identical.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. DIVU of the same operands → 0 (not special).
- Backpressure: hold `div_wb_ready=0` for 5 cycles in DONE → valid and result stable, `ix_div_ready=0`. Raise ready → completes, `ix_div_ready=1` the next cycle, and a new DIV is accepted.
- `flush` at CALC cycle 10 → `div_wb_valid` never rises, IDLE the next cycle; a following REMU 0xFFFFFFFF/16 → 0xF.
- Assert `rst_n` mid-CALC → outputs at reset values asynchronously. After release, DIV 0x7FFFFFFF/−1 → 0x80000001.
